// File: rtl/route_sequencer.sv
// Route step sequencer: sensor sync/debounce, per-step advance conditions, dwell timer and
// registered motor/turnout outputs. Optional watchdog enabled by defining ROUTE_WDOG_EN.
module route_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned DWELL_CYCLES    = 50_000_000,
   parameter int unsigned WDOG_CYCLES     = 500_000_000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [5:0] Sensors,
   input  logic       Run,
   output logic [3:0] Selector,
   output logic       Advance,
   output logic [1:0] Motor,
   output logic       SwitchA,
   output logic       SwitchB,
   output logic       TimerDone,
   output logic       Fault
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TM_W = $clog2(DWELL_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TM_W-1:0] TM_LOAD = TM_W'(DWELL_CYCLES);

   if (DEBOUNCE_CYCLES < 1 || DWELL_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_bad_params
      $error("route_sequencer: cycle parameters must be >= 1");
   end

`ifdef ROUTE_WDOG_EN
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_FAULT} state_t;
   localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
   logic [WD_W-1:0] r_wdog;
   logic [WD_W-1:0] w_wdog_nxt;
   logic            r_fault;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;
`endif

   logic [5:0]      r_sync1;
   logic [5:0]      r_sync2;
   logic [5:0]      r_deb;
   logic [DB_W-1:0] r_dbcnt [6];

   state_t          r_state;
   logic [3:0]      r_sel;
   logic            r_armed;
   logic [TM_W-1:0] r_timer;
   logic            r_adv;
   logic [1:0]      r_motor;
   logic            r_swa;
   logic            r_swb;
   logic            r_tdone;

   state_t          w_state_nxt;
   logic [3:0]      w_sel_nxt;
   logic            w_armed_nxt;
   logic [TM_W-1:0] w_timer_nxt;
   logic            w_adv;
   logic            w_cond;
   logic            w_dwell;

   function automatic logic f_dwell(input logic [3:0] s);
      return (s >= 4'd2) && (s <= 4'd5);
   endfunction

   function automatic logic [1:0] f_motor(input logic [3:0] s);
      if (f_dwell(s))      return 2'b00;
      else if (s <= 4'd9)  return 2'b01;
      else                 return 2'b10;
   endfunction

   // A debounced bit flips only after the synchronised bit has disagreed with it
   // for DEBOUNCE_CYCLES consecutive samples.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         for (int unsigned i = 0; i < 6; i++) r_dbcnt[i] <= '0;
      end else begin
         r_sync1 <= Sensors;
         r_sync2 <= r_sync1;
         for (int unsigned i = 0; i < 6; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_dbcnt[i] <= '0;
            end else if (r_dbcnt[i] == DB_LAST) begin
               r_deb[i]   <= r_sync2[i];
               r_dbcnt[i] <= '0;
            end else begin
               r_dbcnt[i] <= r_dbcnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign w_dwell = f_dwell(r_sel);

   always_comb begin
      w_cond = 1'b0;
      case (r_sel)
         4'd0:                   w_cond = r_deb[0] | r_deb[5];
         4'd1:                   w_cond = r_deb[1] | r_deb[4];
         4'd2, 4'd3, 4'd4, 4'd5: w_cond = (r_timer == '0);
         4'd6, 4'd9:             w_cond = r_deb[2];
         4'd7, 4'd8:             w_cond = r_deb[3];
         4'd10:                  w_cond = ~|r_deb[3:0];
         4'd11:                  w_cond = ~|r_deb[5:2];
         4'd12, 4'd14:           w_cond = r_deb[5];
         default:                w_cond = r_deb[0];
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_armed_nxt = r_armed;
      w_timer_nxt = r_timer;
      w_adv       = 1'b0;
`ifdef ROUTE_WDOG_EN
      w_wdog_nxt  = r_wdog;
`endif
      case (r_state)
         ST_IDLE, ST_HOLD: begin
            if (Run) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // Dropping Run takes priority over a qualifying condition in the same cycle.
            if (!Run) begin
               w_state_nxt = ST_HOLD;
            end else if ((r_armed || w_dwell) && w_cond) begin
               w_sel_nxt   = r_sel + 4'd1;
               w_adv       = 1'b1;
               w_armed_nxt = 1'b0;
               if (f_dwell(w_sel_nxt)) w_timer_nxt = TM_LOAD;
`ifdef ROUTE_WDOG_EN
               w_wdog_nxt  = '0;
`endif
            end else begin
               if (!w_cond) w_armed_nxt = 1'b1;
               if (w_dwell && (r_timer != '0)) w_timer_nxt = r_timer - TM_W'(1);
`ifdef ROUTE_WDOG_EN
               if (!w_dwell) begin
                  if (r_wdog == WD_LAST) w_state_nxt = ST_FAULT;
                  w_wdog_nxt = r_wdog + WD_W'(1);
               end
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
         r_armed <= 1'b0;
         r_timer <= '0;
         r_adv   <= 1'b0;
         r_motor <= 2'b00;
         r_swa   <= 1'b0;
         r_swb   <= 1'b0;
         r_tdone <= 1'b0;
`ifdef ROUTE_WDOG_EN
         r_wdog  <= '0;
         r_fault <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_armed <= w_armed_nxt;
         r_timer <= w_timer_nxt;
         r_adv   <= w_adv;
         r_tdone <= f_dwell(w_sel_nxt) && (w_timer_nxt == '0);
         // Outputs decode the next step so they change together with Selector.
         if (w_state_nxt == ST_RUN) begin
            r_motor <= f_motor(w_sel_nxt);
            r_swa   <= (w_sel_nxt >= 4'd6) && (w_sel_nxt <= 4'd9);
            r_swb   <= (w_sel_nxt >= 4'd12);
         end else begin
            r_motor <= 2'b00;
         end
`ifdef ROUTE_WDOG_EN
         r_wdog  <= w_wdog_nxt;
         r_fault <= (w_state_nxt == ST_FAULT);
`endif
      end
   end

   assign Selector  = r_sel;
   assign Advance   = r_adv;
   assign Motor     = r_motor;
   assign SwitchA   = r_swa;
   assign SwitchB   = r_swb;
   assign TimerDone = r_tdone;
`ifdef ROUTE_WDOG_EN
   assign Fault     = r_fault;
`else
   assign Fault     = 1'b0;
`endif

endmodule

// File: doc/route_sequencer.md
# route_sequencer

Clocked controller that steps the train route through its 16 route steps. Synchronises and debounces the six track sensors and evaluates each step's advance condition. Runs the station dwell timer and drives the route step index, motor command and turnout outputs. Replaces free-running selection with a single registered state machine that owns the step index consumed by the sensor-select path.

## Interface
- DEBOUNCE_CYCLES, 4: cycles a synchronised sensor must be stable before its debounced value changes (≥1).
- DWELL_CYCLES, 50_000_000: station dwell length in clock cycles (≥1), loaded on entry to steps 2–5.
- WDOG_CYCLES, 500_000_000: watchdog limit in cycles (used only with ROUTE_WDOG_EN).
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Sensors  in  6  raw track sensors, bit0 = S1 … bit5 = S6, active high, asynchronous.
- Run  in  1  level; 1 = route may progress, 0 = hold.
- Selector  out  4  current route step 0–15.
- Advance  out  1  one-cycle pulse coincident with each Selector change.
- Motor  out  2  00 stop, 01 forward, 10 reverse (11 never driven).
- SwitchA  out  1  turnout A thrown.
- SwitchB  out  1  turnout B thrown.
- TimerDone  out  1  dwell timer at zero while in a dwell step.
- Fault  out  1  watchdog tripped.

## Operation
- Reset values: Selector=0, Advance=0, Motor=00, SwitchA=0, SwitchB=0, TimerDone=0, Fault=0, state IDLE, debounced sensors=0, armed=0, timer=0.
- Sensor path: per bit, 2-flop synchroniser, then debounce counter. Debounced bit takes the synchronised value after it is stable for DEBOUNCE_CYCLES consecutive cycles.
- Step condition C(step) on debounced sensors D1–D6:
  - 0: D1|D6
  - 1: D2|D5
  - 2–5: timer==0
  - 6: D3
  - 7: D4
  - 8: D4
  - 9: D3
  - 10: ~(D1|D2|D3|D4)
  - 11: ~(D3|D4|D5|D6)
  - 12: D6
  - 13: D1
  - 14: D6
  - 15: D1
- Arming: on step entry, armed=0. armed sets once C(step) is false for a cycle in RUN. Dwell steps 2–5 are always armed.
- States:
  - IDLE: Motor stop. Run=1 → RUN.
  - RUN: if armed and C(step) → Selector+1 (15 wraps to 0), Advance=1, armed=0. Timer loads DWELL_CYCLES when the new step is 2–5. Run=0 → HOLD.
  - HOLD: Motor stop. Selector, timer, and armed frozen. Run=1 → RUN.
  - FAULT: only with ROUTE_WDOG_EN; exit by reset only.
- Timer: decrements by 1 per RUN cycle while in steps 2–5 and nonzero; saturates at 0.
- Outputs decoded from registered Selector and state, in RUN only:
  - Motor: 00 for steps 2–5; 01 for steps 0–1 and 6–9; 10 for steps 10–15.
  - SwitchA = 1 for steps 6–9. SwitchB = 1 for steps 12–15. Switches hold their value in HOLD.
- Simultaneous events: Run falling in the same cycle a condition qualifies → HOLD wins, no advance.

## Timing
- Sensor edge to debounced change: 2 + DEBOUNCE_CYCLES cycles.
- Debounced qualifying condition to Selector/Advance: 1 cycle (registered).
- Dwell: step entry to the Advance leaving the step = DWELL_CYCLES + 1 RUN cycles.
- Motor/Switch outputs follow Selector in the same cycle (registered decode).
- RST_N assertion mid-route: all outputs return to reset values immediately (asynchronously). Release is sampled on the next CLK edge.

## Configuration
- ROUTE_WDOG_EN defined: a cycle counter clears on every Advance and counts in RUN steps other than 2–5. On reaching WDOG_CYCLES: state FAULT, Fault=1, Motor=00, Selector frozen.
- ROUTE_WDOG_EN undefined: no counter, Fault constant 0, FAULT state absent.

## Test plan
(DEBOUNCE_CYCLES=2, DWELL_CYCLES=10, WDOG_CYCLES=100)
- Reset, Run=1, Sensors=0 → Selector=0, Motor=01. Assert S1 → Advance pulse 5 cycles later, Selector=1.
- Step 1→2 via S5 → Motor=00, TimerDone=1 after 10 cycles; Selector reaches 6 after ~44 further cycles.
- In step 7 hold S4=1 → advance to 8; Selector stays 8 until S4 drops ≥3 cycles and reasserts.
- 1-cycle glitch on S3 in step 6 → no advance.
- Run=0 during step 3 dwell for 20 cycles → Motor=00, timer frozen. Run=1 → dwell resumes with the remaining count.
- ROUTE_WDOG_EN: step 0, no sensors, 100 cycles → Fault=1, Motor=00. Run toggles have no effect until RST_N=0.
